// File: rtl/conv33_line_sched.sv
// conv33_line_sched: raster-stream scheduler for a 3x3 convolution datapath.
// Keeps two line buffers, presents one (top, mid, bot) image column per
// accepted pixel, marks datapath outputs that are full interior windows and
// sequences IDLE -> FILL -> RUN -> DONE for each frame.
module conv33_line_sched #(
    parameter int PIXEL_WIDTH = 8,
    parameter int IMG_W       = 64,
    parameter int IMG_H       = 64
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [1:0]             mode_in,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [PIXEL_WIDTH-1:0] in_pixel,
    output logic [PIXEL_WIDTH-1:0] pix_top,
    output logic [PIXEL_WIDTH-1:0] pix_mid,
    output logic [PIXEL_WIDTH-1:0] pix_bot,
    output logic                   conv_ce,
    output logic [1:0]             mode,
    output logic                   out_valid,
    output logic                   out_last,
    output logic                   busy,
    output logic                   done
);

    localparam int CW = $clog2(IMG_W);
    localparam int RW = $clog2(IMG_H);

    localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
    localparam logic [CW-1:0] COL_ONE  = CW'(1);
    localparam logic [CW-1:0] COL_TWO  = CW'(2);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);
    localparam logic [RW-1:0] ROW_ONE  = RW'(1);
    localparam logic [RW-1:0] ROW_TWO  = RW'(2);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_FILL = 2'd1,
        S_RUN  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t                 state_q, state_d;
    logic [CW-1:0]          col_q, col_d;
    logic [RW-1:0]          row_q, row_d;
    logic [1:0]             mode_q, mode_d;
    logic [PIXEL_WIDTH-1:0] pix_top_q, pix_top_d;
    logic [PIXEL_WIDTH-1:0] pix_mid_q, pix_mid_d;
    logic [PIXEL_WIDTH-1:0] pix_bot_q, pix_bot_d;
    logic                   conv_ce_q, conv_ce_d;
    logic                   win1_q, win1_d;
    logic                   win2_q, win2_d;
    logic                   last1_q, last1_d;
    logic                   last2_q, last2_d;
    logic                   done_q, done_d;

    // Line buffers: lb0 holds row r-2, lb1 holds row r-1 for the current column.
    logic [PIXEL_WIDTH-1:0] lb0_q [IMG_W];
    logic [PIXEL_WIDTH-1:0] lb1_q [IMG_W];

    logic                   ready_s;
    logic                   accept_s;
    logic                   col_last_s;
    logic                   row_last_s;
    logic [PIXEL_WIDTH-1:0] lb_rd0_s;
    logic [PIXEL_WIDTH-1:0] lb_rd1_s;

    assign ready_s    = (state_q == S_FILL) || (state_q == S_RUN);
    assign accept_s   = in_valid && ready_s;
    assign col_last_s = (col_q == COL_LAST);
    assign row_last_s = (row_q == ROW_LAST);
    assign lb_rd0_s   = lb0_q[col_q];
    assign lb_rd1_s   = lb1_q[col_q];

    // Next-state, counter, column-output and window-flag pipeline logic.
    always_comb begin
        state_d   = state_q;
        row_d     = row_q;
        col_d     = col_q;
        mode_d    = mode_q;
        pix_top_d = pix_top_q;
        pix_mid_d = pix_mid_q;
        pix_bot_d = pix_bot_q;
        conv_ce_d = 1'b0;
        win1_d    = 1'b0;
        last1_d   = 1'b0;
        win2_d    = win1_q;
        last2_d   = last1_q;
        done_d    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    mode_d  = mode_in;
                    row_d   = '0;
                    col_d   = '0;
                    state_d = S_FILL;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_FILL, S_RUN: begin
                if (accept_s) begin
                    pix_bot_d = in_pixel;
                    pix_mid_d = lb_rd1_s;
                    pix_top_d = lb_rd0_s;
                    conv_ce_d = 1'b1;
                    // Columns 0-1 and rows 0-1 only prime the datapath.
                    win1_d    = (row_q >= ROW_TWO) && (col_q >= COL_TWO);
                    last1_d   = row_last_s && col_last_s;
                    if (col_last_s) begin
                        col_d = '0;
                        if (row_last_s) begin
                            row_d   = '0;
                            state_d = S_DONE;
                            done_d  = 1'b1;
                        end else begin
                            row_d = row_q + ROW_ONE;
                            if (row_q == ROW_ONE) begin
                                state_d = S_RUN;
                            end else begin
                                state_d = state_q;
                            end
                        end
                    end else begin
                        col_d = col_q + COL_ONE;
                    end
                end else begin
                    conv_ce_d = 1'b0;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State, counters and all registered outputs; reset aborts any frame.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            row_q     <= '0;
            col_q     <= '0;
            mode_q    <= 2'd0;
            pix_top_q <= '0;
            pix_mid_q <= '0;
            pix_bot_q <= '0;
            conv_ce_q <= 1'b0;
            win1_q    <= 1'b0;
            win2_q    <= 1'b0;
            last1_q   <= 1'b0;
            last2_q   <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            row_q     <= row_d;
            col_q     <= col_d;
            mode_q    <= mode_d;
            pix_top_q <= pix_top_d;
            pix_mid_q <= pix_mid_d;
            pix_bot_q <= pix_bot_d;
            conv_ce_q <= conv_ce_d;
            win1_q    <= win1_d;
            win2_q    <= win2_d;
            last1_q   <= last1_d;
            last2_q   <= last2_d;
            done_q    <= done_d;
        end
    end

    // Line-buffer shift on accept: reads above see the pre-write contents.
    always_ff @(posedge clk) begin
        if (accept_s) begin
            lb0_q[col_q] <= lb_rd1_s;
            lb1_q[col_q] <= in_pixel;
        end
    end

    assign in_ready  = ready_s;
    assign busy      = ready_s;
    assign pix_top   = pix_top_q;
    assign pix_mid   = pix_mid_q;
    assign pix_bot   = pix_bot_q;
    assign conv_ce   = conv_ce_q;
    assign mode      = mode_q;
    assign out_valid = win2_q;
    assign out_last  = last2_q;
    assign done      = done_q;

endmodule

// File: tb/tb_conv33_line_sched.sv
// Scoreboard bench for conv33_line_sched: a 4x4 instance driven through
// directed frames, and a 3x3 instance for the single-window case.
module tb_conv33_line_sched;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [1:0] mode_in;
    logic       in_valid;
    logic [7:0] in_pixel;
    logic       in_ready, conv_ce, out_valid, out_last, busy, done;
    logic [7:0] pix_top, pix_mid, pix_bot;
    logic [1:0] mode;

    logic       start3, in_valid3;
    logic [1:0] mode_in3;
    logic [7:0] in_pixel3;
    logic       in_ready3, conv_ce3, out_valid3, out_last3, busy3, done3;
    logic [7:0] pix_top3, pix_mid3, pix_bot3;
    logic [1:0] mode3;

    always #5 clk = ~clk;

    conv33_line_sched #(.PIXEL_WIDTH(8), .IMG_W(4), .IMG_H(4)) dut (
        .clk(clk), .rst(rst), .start(start), .mode_in(mode_in),
        .in_valid(in_valid), .in_ready(in_ready), .in_pixel(in_pixel),
        .pix_top(pix_top), .pix_mid(pix_mid), .pix_bot(pix_bot),
        .conv_ce(conv_ce), .mode(mode), .out_valid(out_valid),
        .out_last(out_last), .busy(busy), .done(done)
    );

    conv33_line_sched #(.PIXEL_WIDTH(8), .IMG_W(3), .IMG_H(3)) dut3 (
        .clk(clk), .rst(rst), .start(start3), .mode_in(mode_in3),
        .in_valid(in_valid3), .in_ready(in_ready3), .in_pixel(in_pixel3),
        .pix_top(pix_top3), .pix_mid(pix_mid3), .pix_bot(pix_bot3),
        .conv_ce(conv_ce3), .mode(mode3), .out_valid(out_valid3),
        .out_last(out_last3), .busy(busy3), .done(done3)
    );

    typedef struct {
        int         cyc;
        logic [7:0] top;
        logic [7:0] mid;
        logic [7:0] bot;
    } col_t;

    typedef struct {
        int   cyc;
        logic last;
    } win_t;

    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;
    col_t exp_cols[$];
    win_t exp_wins[$];
    int   exp_dones[$];
    col_t last_exp;
    int   win_seen = 0, last_seen = 0, done_seen = 0;
    logic cap_first = 1'b0;
    logic [7:0] fw_top, fw_mid, fw_bot;
    logic [7:0] prev_top, prev_mid, prev_bot;

    // Reference model state
    logic [7:0] m_lb0[4];
    logic [7:0] m_lb1[4];
    int         mr, mc;
    logic       exp_ready;
    logic [1:0] exp_mode;

    int v3 = 0, l3 = 0, d3 = 0, c3 = 0;
    logic [7:0] w3_top, w3_mid, w3_bot;
    logic [7:0] p3_top, p3_mid, p3_bot;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    // Skips fields whose expected value is not yet defined (unwritten line buffer).
    task automatic check_px(input string name, input logic [7:0] act, input logic [7:0] expv);
        if (!$isunknown(expv)) check(name, {24'd0, act}, {24'd0, expv});
    endtask

    // Monitor / scoreboard for the 4x4 instance
    always @(negedge clk) begin
        if (!rst) begin
            if (conv_ce) begin
                if (exp_cols.size() == 0) begin
                    check("col_unexpected", 32'd1, 32'd0);
                end else begin
                    col_t e;
                    e = exp_cols.pop_front();
                    check("col_cycle", cyc, e.cyc);
                    check_px("pix_top", pix_top, e.top);
                    check_px("pix_mid", pix_mid, e.mid);
                    check_px("pix_bot", pix_bot, e.bot);
                    last_exp = e;
                end
            end else begin
                check_px("hold_top", pix_top, last_exp.top);
                check_px("hold_mid", pix_mid, last_exp.mid);
                check_px("hold_bot", pix_bot, last_exp.bot);
            end
            if (out_valid) begin
                if (cap_first) begin
                    fw_top = prev_top; fw_mid = prev_mid; fw_bot = prev_bot;
                    cap_first = 1'b0;
                end
                if (exp_wins.size() == 0) begin
                    check("win_unexpected", 32'd1, 32'd0);
                end else begin
                    win_t w;
                    w = exp_wins.pop_front();
                    check("win_cycle", cyc, w.cyc);
                    check("out_last", {31'd0, out_last}, {31'd0, w.last});
                end
                win_seen++;
                if (out_last) last_seen++;
            end else begin
                check("out_last_alone", {31'd0, out_last}, 32'd0);
            end
            if (done) begin
                if (exp_dones.size() == 0) begin
                    check("done_unexpected", 32'd1, 32'd0);
                end else begin
                    check("done_cycle", cyc, exp_dones.pop_front());
                end
                done_seen++;
            end
            prev_top = pix_top; prev_mid = pix_mid; prev_bot = pix_bot;
        end
    end

    // Observer for the 3x3 instance
    always @(negedge clk) begin
        if (!rst) begin
            if (conv_ce3) c3++;
            if (out_valid3) begin
                v3++;
                w3_top = p3_top; w3_mid = p3_mid; w3_bot = p3_bot;
                if (out_last3) l3++;
            end
            if (done3) d3++;
            p3_top = pix_top3; p3_mid = pix_mid3; p3_bot = pix_bot3;
        end
    end

    task automatic start_frame(input logic [1:0] m);
        @(negedge clk);
        in_valid = 1'b0; start = 1'b1; mode_in = m;
        check("ready_idle", {31'd0, in_ready}, 32'd0);
        exp_ready = 1'b1; exp_mode = m; mr = 0; mc = 0;
    endtask

    task automatic feed(input logic v, input logic [7:0] p, input logic st, input logic [1:0] mi);
        col_t e;
        win_t w;
        @(negedge clk);
        in_valid = v; in_pixel = p; start = st; mode_in = mi;
        check("in_ready", {31'd0, in_ready}, {31'd0, exp_ready});
        check("busy", {31'd0, busy}, {31'd0, exp_ready});
        check("mode", {30'd0, mode}, {30'd0, exp_mode});
        if (v && exp_ready) begin
            e.cyc = cyc + 1; e.top = m_lb0[mc]; e.mid = m_lb1[mc]; e.bot = p;
            exp_cols.push_back(e);
            m_lb0[mc] = m_lb1[mc];
            m_lb1[mc] = p;
            if (mr >= 2 && mc >= 2) begin
                w.cyc = cyc + 2; w.last = (mr == 3 && mc == 3);
                exp_wins.push_back(w);
            end
            if (mr == 3 && mc == 3) begin
                exp_dones.push_back(cyc + 1);
                exp_ready = 1'b0;
            end
            if (mc == 3) begin mc = 0; mr++; end
            else mc++;
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            in_valid = 1'b0; start = 1'b0;
            check("ready_gap", {31'd0, in_ready}, {31'd0, exp_ready});
            check("mode_idle", {30'd0, mode}, {30'd0, exp_mode});
        end
    endtask

    task automatic frame(input logic [7:0] base, input logic gaps, input logic [1:0] mi,
                         input logic [1:0] mi_late, input int start_at);
        for (int i = 0; i < 16; i++) begin
            if (gaps) feed(1'b0, 8'hEE, 1'b0, mi);
            feed(1'b1, base + 8'(i), (i == start_at), (i >= 3) ? mi_late : mi);
        end
    endtask

    task automatic expect_counts(input string name, input int w0, input int l0, input int d0,
                                 input int dw, input int dl, input int dd);
        check({name, "_windows"}, win_seen - w0, dw);
        check({name, "_lasts"}, last_seen - l0, dl);
        check({name, "_dones"}, done_seen - d0, dd);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1);
    end

    initial begin
        int w0, l0, d0;
        for (int i = 0; i < 4; i++) begin m_lb0[i] = 'x; m_lb1[i] = 'x; end
        last_exp = '{0, 8'd0, 8'd0, 8'd0};
        exp_ready = 1'b0; exp_mode = 2'd0; mr = 0; mc = 0;
        rst = 1'b1; start = 1'b0; mode_in = 2'd0; in_valid = 1'b0; in_pixel = 8'd0;
        start3 = 1'b0; mode_in3 = 2'd0; in_valid3 = 1'b0; in_pixel3 = 8'd0;
        repeat (2) @(negedge clk);
        check("rst_ready", {31'd0, in_ready}, 32'd0);
        check("rst_outs", {26'd0, conv_ce, out_valid, out_last, busy, done, 1'b0},
              32'd0);
        check("rst_pix", {8'd0, pix_top, pix_mid, pix_bot}, 32'd0);
        check("rst_mode", {30'd0, mode}, 32'd0);
        #1 rst = 1'b0;

        // 1: plain 4x4 frame, pixel = 4*row+col
        w0 = win_seen; l0 = last_seen; d0 = done_seen;
        cap_first = 1'b1;
        start_frame(2'd0);
        frame(8'd0, 1'b0, 2'd0, 2'd0, -1);
        idle(4);
        expect_counts("s1", w0, l0, d0, 4, 1, 1);
        check("first_win_top", {24'd0, fw_top}, 32'd2);
        check("first_win_mid", {24'd0, fw_mid}, 32'd6);
        check("first_win_bot", {24'd0, fw_bot}, 32'd10);

        // 2: same frame with valid gaps
        w0 = win_seen; l0 = last_seen; d0 = done_seen;
        start_frame(2'd0);
        frame(8'd0, 1'b1, 2'd0, 2'd0, -1);
        idle(4);
        expect_counts("s2", w0, l0, d0, 4, 1, 1);

        // 3: mode latched at start, mid-frame mode change and start ignored
        w0 = win_seen; l0 = last_seen; d0 = done_seen;
        start_frame(2'd2);
        frame(8'd40, 1'b0, 2'd2, 2'd1, 10);
        idle(4);
        expect_counts("s3", w0, l0, d0, 4, 1, 1);
        check("s3_mode_kept", {30'd0, mode}, 32'd2);

        // 4: reset in place of accept 9, then a clean frame
        w0 = win_seen; l0 = last_seen; d0 = done_seen;
        start_frame(2'd1);
        for (int i = 0; i < 9; i++) feed(1'b1, 8'(i), 1'b0, 2'd1);
        @(negedge clk);
        #1 rst = 1'b1; in_valid = 1'b1; in_pixel = 8'd9;
        exp_cols.delete(); exp_wins.delete(); exp_dones.delete();
        last_exp = '{0, 8'd0, 8'd0, 8'd0};
        exp_ready = 1'b0; exp_mode = 2'd0; mr = 0; mc = 0;
        @(negedge clk);
        check("abort_ready", {31'd0, in_ready}, 32'd0);
        check("abort_outs", {27'd0, conv_ce, out_valid, out_last, busy, done}, 32'd0);
        check("abort_pix", {8'd0, pix_top, pix_mid, pix_bot}, 32'd0);
        check("abort_mode", {30'd0, mode}, 32'd0);
        #1 rst = 1'b0; in_valid = 1'b0;
        idle(2);
        start_frame(2'd0);
        frame(8'd0, 1'b0, 2'd0, 2'd0, -1);
        idle(4);
        expect_counts("s4", w0, l0, d0, 4, 1, 1);

        // 5: back-to-back frames, second start in the cycle after done
        w0 = win_seen; l0 = last_seen; d0 = done_seen;
        start_frame(2'd0);
        frame(8'd0, 1'b0, 2'd0, 2'd0, -1);
        idle(1);
        start_frame(2'd1);
        frame(8'd100, 1'b0, 2'd1, 2'd1, -1);
        idle(4);
        expect_counts("s5", w0, l0, d0, 8, 2, 2);

        check("cols_drained", exp_cols.size(), 32'd0);
        check("wins_drained", exp_wins.size(), 32'd0);
        check("dones_drained", exp_dones.size(), 32'd0);

        // 6: 3x3 image, pixel = 3*row+col -> a single window, column (2,5,8)
        @(negedge clk);
        start3 = 1'b1; mode_in3 = 2'd1;
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            start3 = 1'b0; in_valid3 = 1'b1; in_pixel3 = 8'(i);
            check("r3_ready", {31'd0, in_ready3}, 32'd1);
        end
        @(negedge clk);
        in_valid3 = 1'b0;
        repeat (5) @(negedge clk);
        check("r3_windows", v3, 32'd1);
        check("r3_lasts", l3, 32'd1);
        check("r3_dones", d3, 32'd1);
        check("r3_columns", c3, 32'd9);
        check("r3_win_col", {8'd0, w3_top, w3_mid, w3_bot}, {8'd0, 8'd2, 8'd5, 8'd8});
        check("r3_mode", {30'd0, mode3}, 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/conv33_line_sched.md
# conv33_line_sched

Streaming scheduler that feeds the 3x3 convolution datapath from a raster-order pixel stream. It holds two line buffers and drives the datapath's three row inputs (top/mid/bot) plus a clock-enable, so the datapath sees one image column per accepted pixel. It tracks row/column position, flags which datapath outputs are valid full 3x3 windows (no border output), latches the filter mode per frame, and sequences frame start/fill/run/done. It sits between the pixel source and the conv datapath.

## Interface
- PIXEL_WIDTH, 8, bits per pixel
- IMG_W, 64, image width in pixels (>=3)
- IMG_H, 64, image height in rows (>=3)

- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- start  in  1  begin a frame; sampled only in IDLE
- mode_in  in  2  filter select (0 sharpen, 1 gaussian, 2 edge); latched on start
- in_valid  in  1  source pixel valid
- in_ready  out  1  scheduler accepts a pixel this cycle
- in_pixel  in  PIXEL_WIDTH  raster-order pixel
- pix_top / pix_mid / pix_bot  out  PIXEL_WIDTH each  column to datapath (rows r-2, r-1, r)
- conv_ce  out  1  datapath shift/compute enable, one pulse per column
- mode  out  2  latched mode to datapath
- out_valid  out  1  datapath output this cycle is a valid interior pixel
- out_last  out  1  with out_valid: final window of frame
- busy  out  1  frame in progress (FILL or RUN)
- done  out  1  one-cycle pulse at frame end

## Operation
- States: IDLE, FILL, RUN, DONE.
- IDLE: in_ready=0. start=1 -> latch mode_in into mode, clear row/col counters, go FILL.
- FILL (rows 0-1) and RUN (rows 2..IMG_H-1): in_ready=1. Accept = in_valid & in_ready.
- On accept at (row, col): pix_bot<=in_pixel, pix_mid<=lb1[col], pix_top<=lb0[col]; lb0[col]<=lb1[col]; lb1[col]<=in_pixel (read returns pre-write value). conv_ce<=1; else conv_ce<=0 and pix_* hold.
- col increments per accept, wraps IMG_W-1 -> 0 and increments row. Row 1 last column -> RUN. Last pixel (IMG_H-1, IMG_W-1) accepted -> DONE.
- Window flag win = (row>=2) & (col>=2) at accept; window centre is (row-1, col-1). Windows per frame = (IMG_W-2)*(IMG_H-2). Columns 0-1 of each row are fed (priming the datapath shift registers) but not flagged.
- DONE: in_ready=0, done=1 for that single cycle, then IDLE.
- Counters are $clog2(IMG_W) and $clog2(IMG_H) bits wide; no other arithmetic.
- start outside IDLE is ignored; mode_in changes mid-frame are ignored.
- in_valid gaps: no effect except conv_ce=0 that cycle; window state is preserved.
- Line buffer contents are not reset; rows 0-1 overwrite them before any flagged window reads them.

## Timing
- Reset: state IDLE; in_ready, conv_ce, pix_top/mid/bot, mode, out_valid, out_last, busy, done all 0; counters 0. Reset mid-frame aborts immediately with no done pulse.
- in_ready and busy decode combinationally from state.
- start at cycle T -> FILL and in_ready=1 at T+1.
- Accept at cycle N -> pix_* and conv_ce at N+1 (datapath captures at edge N+1->N+2) -> datapath output and out_valid/out_last at N+2.
- out_valid = win delayed two cycles; out_last = final-window flag delayed two cycles.
- Last pixel accepted at N -> DONE at N+1 (done=1), IDLE at N+2; out_last at N+2. A new start is accepted at N+2 and does not disturb the in-flight out_valid pipeline.

## Test plan
- IMG_W=IMG_H=4, pixel = 4*row+col, in_valid always 1 -> 16 accepts; first out_valid cycle shows pix_top=2, pix_mid=6, pix_bot=10 one cycle earlier with conv_ce=1; exactly 4 out_valid pulses, out_last on the 4th; done one cycle after the last accept.
- Same frame with in_valid toggling 1/0 -> identical pix_* sequence on conv_ce cycles; conv_ce=0 and pix_* held in gap cycles; same 4 windows.
- mode_in=2 at start, changed to 1 mid-frame -> mode stays 2 until the next start; start pulsed in RUN -> ignored, counters unaffected.
- rst asserted at accept 9 -> all outputs 0 next cycle, IDLE, no done; a following full frame gives the same results as scenario 1.
- Back-to-back frames, start at the done+1 cycle -> second frame's first window is correct (the old line-buffer contents are never flagged); out_last of frame 1 is not lost.
- IMG_W=IMG_H=3 -> exactly one out_valid with out_last=1.
